// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample in, INTERPOLATION filtered outputs out.
// Build option: define FIR_INTERP_GAIN_EN to scale each output by INTERPOLATION (wrapping).
module fir_interp #(
   parameter int unsigned TAPS          = 32,
   parameter int unsigned INTERPOLATION = 4,
   parameter int unsigned DATA_SIZE     = 32,
   parameter int unsigned QUANT_BITS    = 10,
   parameter logic [0:TAPS-1][DATA_SIZE-1:0] GLOBAL_COEFF = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_SIZE-1:0] x_in,
   input  logic                 x_empty,
   output logic                 x_rd_en,
   output logic [DATA_SIZE-1:0] y_out,
   input  logic                 y_out_full,
   output logic                 y_wr_en
);

   localparam int unsigned L       = TAPS / INTERPOLATION;
   localparam int unsigned K_W     = (L > 1) ? $clog2(L) : 1;
   localparam int unsigned P_W     = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
   localparam int unsigned I_W     = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int unsigned GAIN_SH = $clog2(INTERPOLATION);
   localparam int unsigned PW2     = 2 * DATA_SIZE;

   typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;

   state_t               state, state_nx;
   logic [DATA_SIZE-1:0] d [0:L-1];
   logic [DATA_SIZE-1:0] acc;
   logic [DATA_SIZE-1:0] y_hold;
   logic [DATA_SIZE-1:0] wval;
   logic [DATA_SIZE-1:0] tap;
   logic [DATA_SIZE-1:0] coef;
   logic [DATA_SIZE-1:0] term;
   logic [K_W-1:0]       k;
   logic [P_W-1:0]       phase;
   logic [I_W-1:0]       cidx;
   logic [PW2-1:0]       a_ext;
   logic [PW2-1:0]       b_ext;
   logic [PW2-1:0]       prod;
   logic                 last_tap;
   logic                 last_phase;

   // Dequantise toward zero: shift the magnitude, then restore the sign.
   function automatic logic [DATA_SIZE-1:0] deq(input logic [PW2-1:0] p);
      logic [PW2-1:0] mag;
      if (p[PW2-1]) begin
         mag = (~p + 1'b1) >> QUANT_BITS;
         return DATA_SIZE'(~mag + 1'b1);
      end
      return DATA_SIZE'(p >> QUANT_BITS);
   endfunction

   assign last_tap   = (k == K_W'(L - 1));
   assign last_phase = (phase == P_W'(INTERPOLATION - 1));

   // Branch p, tap k of the polyphase filter uses coefficient p + k*INTERPOLATION.
   always_comb begin
      cidx  = I_W'(k) * I_W'(INTERPOLATION) + I_W'(phase);
      coef  = GLOBAL_COEFF[cidx];
      tap   = d[k];
      a_ext = {{DATA_SIZE{tap[DATA_SIZE-1]}}, tap};
      b_ext = {{DATA_SIZE{coef[DATA_SIZE-1]}}, coef};
      prod  = a_ext * b_ext;
      term  = deq(prod);
   end

   always_comb begin
`ifdef FIR_INTERP_GAIN_EN
      wval = acc << GAIN_SH;
`else
      wval = acc;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_READ;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_READ:  if (!x_empty) state_nx = S_MAC;
         S_MAC:   if (last_tap) state_nx = S_WRITE;
         S_WRITE: if (!y_out_full) state_nx = last_phase ? S_READ : S_MAC;
         default: state_nx = S_READ;
      endcase
   end

   // Strobes are gated by reset so they stay low while reset is held.
   always_comb begin
      x_rd_en = 1'b0;
      y_wr_en = 1'b0;
      y_out   = y_hold;
      case (state)
         S_READ:  x_rd_en = reset & ~x_empty;
         S_WRITE: begin
            y_wr_en = reset & ~y_out_full;
            y_out   = wval;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < L; i++) d[i] <= '0;
         acc    <= '0;
         y_hold <= '0;
         k      <= '0;
         phase  <= '0;
      end else begin
         case (state)
            S_READ: begin
               if (!x_empty) begin
                  for (int unsigned i = L - 1; i > 0; i--) d[i] <= d[i-1];
                  d[0]  <= x_in;
                  phase <= '0;
                  acc   <= '0;
                  k     <= '0;
               end
            end
            S_MAC: begin
               acc <= acc + term;
               k   <= last_tap ? '0 : k + 1'b1;
            end
            S_WRITE: begin
               if (!y_out_full) begin
                  y_hold <= wval;
                  if (!last_phase) begin
                     phase <= phase + 1'b1;
                     acc   <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: three instances (ramp, unity, 1023 coefficients) share stimulus.
module tb_fir_interp;

   typedef logic [0:31][31:0] coef_t;

   function automatic coef_t mk_ramp();
      coef_t c;
      for (int j = 0; j < 32; j++) c[j] = 32'(j + 1);
      return c;
   endfunction

   function automatic coef_t mk_first(input int v);
      coef_t c;
      c    = '0;
      c[0] = 32'(v);
      return c;
   endfunction

   localparam coef_t C_IMP = mk_ramp();
   localparam coef_t C_UNI = mk_first(1024);
   localparam coef_t C_RND = mk_first(1023);
`ifdef FIR_INTERP_GAIN_EN
   localparam int GS = 2;
`else
   localparam int GS = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] x_in = '0;
   logic        x_empty = 1'b1;
   logic        y_out_full = 1'b0;
   logic        rd_i, wr_i, rd_u, wr_u, rd_r, wr_r;
   logic [31:0] y_i, y_u, y_r;
   logic [31:0] yi, yu, yr;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   fir_interp #(.TAPS(32), .INTERPOLATION(4), .DATA_SIZE(32), .QUANT_BITS(10), .GLOBAL_COEFF(C_IMP)) u_imp (
      .clock(clock), .reset(reset), .x_in(x_in), .x_empty(x_empty), .x_rd_en(rd_i),
      .y_out(y_i), .y_out_full(y_out_full), .y_wr_en(wr_i));
   fir_interp #(.TAPS(32), .INTERPOLATION(4), .DATA_SIZE(32), .QUANT_BITS(10), .GLOBAL_COEFF(C_UNI)) u_uni (
      .clock(clock), .reset(reset), .x_in(x_in), .x_empty(x_empty), .x_rd_en(rd_u),
      .y_out(y_u), .y_out_full(y_out_full), .y_wr_en(wr_u));
   fir_interp #(.TAPS(32), .INTERPOLATION(4), .DATA_SIZE(32), .QUANT_BITS(10), .GLOBAL_COEFF(C_RND)) u_rnd (
      .clock(clock), .reset(reset), .x_in(x_in), .x_empty(x_empty), .x_rd_en(rd_r),
      .y_out(y_r), .y_out_full(y_out_full), .y_wr_en(wr_r));

   function automatic logic [31:0] sc(input int v);
      return 32'(v) << GS;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic send(input logic [31:0] v);
      int n = 0;
      x_in    = v;
      x_empty = 1'b0;
      #1;
      while (!rd_i && n < 200) begin
         @(negedge clock); #1;
         n++;
      end
      chk("rd_wait", 32'(rd_i), 32'd1);
      @(posedge clock); #1;
      x_empty = 1'b1;
   endtask

   task automatic get(output logic [31:0] oi, output logic [31:0] ou, output logic [31:0] orr);
      int n = 0;
      while (!wr_i && n < 200) begin
         @(negedge clock); #1;
         n++;
      end
      chk("wr_wait", 32'(wr_i), 32'd1);
      oi  = y_i;
      ou  = y_u;
      orr = y_r;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      x_empty    = 1'b1;
      y_out_full = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int vin [3];
      int vexp [3];

      // Reset state, with an input offered to show the strobe stays low.
      x_empty = 1'b0;
      x_in    = 32'd123;
      @(negedge clock); #1;
      chk("reset_rd", 32'(rd_i), 32'd0);
      chk("reset_wr", 32'(wr_i), 32'd0);
      chk("reset_y", y_i, 32'd0);
      x_empty = 1'b1;
      @(negedge clock);
      reset = 1'b1;

      // Impulse: outputs walk through the ramp coefficients, then zeros.
      for (int s = 0; s < 9; s++) begin
         send((s == 0) ? 32'd1024 : 32'd0);
         for (int p = 0; p < 4; p++) begin
            get(yi, yu, yr);
            chk($sformatf("impulse_s%0d_p%0d", s, p), yi, (s < 8) ? sc(s * 4 + p + 1) : 32'd0);
         end
      end

      // Unity passthrough.
      do_reset();
      vin[0] = 5; vin[1] = -9;
      for (int s = 0; s < 2; s++) begin
         send(32'(vin[s]));
         for (int p = 0; p < 4; p++) begin
            get(yi, yu, yr);
            chk($sformatf("unity_s%0d_p%0d", s, p), yu, (p == 0) ? sc(vin[s]) : 32'd0);
         end
      end

      // Truncation toward zero with coefficient 1023.
      do_reset();
      vin[0] = -1; vin[1] = 3;  vin[2] = -3;
      vexp[0] = 0; vexp[1] = 2; vexp[2] = -2;
      for (int s = 0; s < 3; s++) begin
         send(32'(vin[s]));
         for (int p = 0; p < 4; p++) begin
            get(yi, yu, yr);
            chk($sformatf("round_s%0d_p%0d", s, p), yr, (p == 0) ? sc(vexp[s]) : 32'd0);
         end
      end

      // Backpressure at the phase-1 write, with a pending input that must not be taken.
      do_reset();
      send(32'd1024);
      get(yi, yu, yr);
      chk("bp_p0", yi, sc(1));
      y_out_full = 1'b1;
      x_empty    = 1'b0;
      x_in       = 32'd777;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock); #1;
         chk($sformatf("bp_wr_%0d", i), 32'(wr_i), 32'd0);
         chk($sformatf("bp_rd_%0d", i), 32'(rd_i), 32'd0);
         if (i >= 9) chk($sformatf("bp_y_%0d", i), y_i, sc(2));
      end
      y_out_full = 1'b0;
      x_empty    = 1'b1;
      #1;
      for (int p = 1; p < 4; p++) begin
         get(yi, yu, yr);
         chk($sformatf("bp_p%0d", p), yi, sc(p + 1));
      end
      send(32'd0);
      for (int p = 0; p < 4; p++) begin
         get(yi, yu, yr);
         chk($sformatf("bp_next_p%0d", p), yi, sc(p + 5));
      end

      // Empty input: no strobes.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         chk($sformatf("empty_rd_%0d", i), 32'(rd_i), 32'd0);
         chk($sformatf("empty_wr_%0d", i), 32'(wr_i), 32'd0);
      end

      // Reset during MAC of the second sample; restart must behave like cold start.
      send(32'd1024);
      for (int p = 0; p < 4; p++) begin
         get(yi, yu, yr);
         chk($sformatf("pre_rst_p%0d", p), yi, sc(p + 1));
      end
      send(32'd0);
      repeat (3) @(negedge clock);
      x_empty = 1'b0;
      reset   = 1'b0;
      #1;
      chk("midrst_y", y_i, 32'd0);
      chk("midrst_rd", 32'(rd_i), 32'd0);
      chk("midrst_wr", 32'(wr_i), 32'd0);
      x_empty = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      send(32'd1024);
      for (int p = 0; p < 4; p++) begin
         get(yi, yu, yr);
         chk($sformatf("post_rst_p%0d", p), yi, sc(p + 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
